// File: rtl/fifo_arb_pkg.sv
// ============================================================================
//  fifo_arb_pkg : shared types and widths for the FIFO write arbiter family
//  Rev 1.0
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int NUM_REQ_DEF    = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 16;
  localparam int MAX_BURST_DEF  = 4;

  localparam int ID_W   = $clog2(NUM_REQ_DEF);
  localparam int CRED_W = $clog2(DEPTH_DEF + 1);

  // Index width that stays at least one bit wide for degenerate counts.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rr_wr_arbiter_if.sv
// ============================================================================
//  fifo_rr_wr_arbiter_if : producer handshakes plus FIFO write/read-return bus
//  Rev 1.0
// ============================================================================
`default_nettype none

interface fifo_rr_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_rd_fire;

  modport master (
    output req_valid, req_data, fifo_rd_fire,
    input  req_ready, fifo_wr_en, fifo_wr_data
  );

  modport slave (
    input  req_valid, req_data, fifo_rd_fire,
    output req_ready, fifo_wr_en, fifo_wr_data
  );

endinterface

`default_nettype wire

// File: rtl/fifo_rr_wr_arbiter_rr_pick.sv
// ============================================================================
//  rr_pick : combinational round-robin picker, searches upward from last+1
//  Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]             valid,
  input  logic [width_of(NUM_REQ)-1:0]   last,
  output logic                           found,
  output logic [width_of(NUM_REQ)-1:0]   idx
);

  localparam int IDW = width_of(NUM_REQ);

  int cand;

  // Walk offsets from farthest to nearest so the nearest valid one wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(last) + k) % NUM_REQ;
      if (valid[cand[IDW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDW-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_rr_wr_arbiter.sv
// ============================================================================
//  fifo_rr_wr_arbiter : round-robin burst arbiter onto one FIFO write port,
//                       with local free-space credit tracking
//  Rev 1.0
// ============================================================================
`default_nettype none

module fifo_rr_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int MAX_BURST  = MAX_BURST_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  fifo_rr_wr_arbiter_if.slave            bus,
  output logic [width_of(NUM_REQ)-1:0]   grant_id,
  output logic [$clog2(DEPTH+1)-1:0]     credits,
  output logic                           credit_err
);

  localparam int IDW = width_of(NUM_REQ);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int BW  = width_of(MAX_BURST);

  state_t                 state_q, state_d;
  logic [IDW-1:0]         owner_q, owner_d;
  logic [IDW-1:0]         last_q, last_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [CW-1:0]          credits_q;
  logic                   err_q;
  logic                   wr_en_q;
  logic [DATA_WIDTH-1:0]  wr_data_q;
  logic [NUM_REQ-1:0]     ready;

  logic                   pick_found;
  logic [IDW-1:0]         pick_idx;
  logic                   cred_nz;
  logic                   owner_valid;
  logic [DATA_WIDTH-1:0]  owner_data;
  logic                   fire;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .valid (bus.req_valid),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign cred_nz     = (credits_q != '0);
  assign owner_valid = bus.req_valid[owner_q];
  assign owner_data  = bus.req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
  assign fire        = owner_valid && ready[owner_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    beat_d  = beat_q;
    ready   = '0;
    case (state_q)
      IDLE: begin
        if (pick_found && cred_nz) begin
          owner_d = pick_idx;
          beat_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // With no credits the owner keeps the grant but sees ready low.
        if (cred_nz) begin
          ready[owner_q] = 1'b1;
        end
        if (fire) begin
          beat_d = beat_q + BW'(1);
          if (beat_q == BW'(MAX_BURST - 1)) begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end else if (!owner_valid) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q <= CW'(DEPTH);
      err_q     <= 1'b0;
    end else begin
      case ({fire, bus.fifo_rd_fire})
        2'b10: credits_q <= credits_q - CW'(1);
        2'b01: begin
          if (credits_q == CW'(DEPTH)) begin
            err_q <= 1'b1;
          end else begin
            credits_q <= credits_q + CW'(1);
          end
        end
        default: credits_q <= credits_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= fire;
      if (fire) begin
        wr_data_q <= owner_data;
      end
    end
  end

  assign bus.req_ready    = ready;
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_wr_data = wr_data_q;
  assign grant_id         = owner_q;
  assign credits          = credits_q;
  assign credit_err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rr_wr_arbiter.sv
// ============================================================================
//  tb_fifo_rr_wr_arbiter : scenario tasks plus randomized run against a
//                          transaction-level credit/write model
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_fifo_rr_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int MB    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [ID_W-1:0]   grant_id;
  logic [CRED_W-1:0] credits;
  logic              credit_err;

  fifo_rr_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus();

  fifo_rr_wr_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_BURST(MB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .grant_id   (grant_id),
    .credits    (credits),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int            cred_m;
  bit            err_m;
  bit            fire_now;
  int            fire_idx;
  logic [DW-1:0] fire_data;
  bit            exp_wr_en;
  logic [DW-1:0] exp_wr_data;
  int            seq [N];
  bit            follow_rd;

  function automatic logic [DW-1:0] word_of(input int i, input int s);
    return DW'((i << 6) | (s & 63));
  endfunction

  task automatic refresh_data();
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = word_of(i, seq[i]);
  endtask

  task automatic model_reset();
    cred_m = DEPTH; err_m = 0; exp_wr_en = 0; exp_wr_data = '0;
    fire_now = 0; fire_idx = -1;
    for (int i = 0; i < N; i++) seq[i] = 0;
    refresh_data();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.req_valid = '0; bus.fifo_rd_fire = 1'b0; follow_rd = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock: observe the handshake, advance producers and the credit model.
  task automatic tick();
    #1;
    fire_now = 0; fire_idx = -1;
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        fire_now = 1; fire_idx = i; fire_data = bus.req_data[i*DW +: DW];
      end
    end
    if (follow_rd) bus.fifo_rd_fire = fire_now;
    if (fire_now && !bus.fifo_rd_fire) cred_m--;
    else if (!fire_now && bus.fifo_rd_fire) begin
      if (cred_m == DEPTH) err_m = 1; else cred_m++;
    end
    @(posedge clk); #1;
    exp_wr_en = fire_now;
    if (fire_now) begin
      exp_wr_data = fire_data;
      seq[fire_idx]++;
      refresh_data();
    end
  endtask

  task automatic test_reset();
    apply_reset(); #1;
    checks++; if (bus.req_ready !== '0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.req_ready); end
    checks++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", bus.fifo_wr_en); end
    checks++; if (bus.fifo_wr_data !== '0) begin errors++; $display("FAIL reset_wr_data got %h want 0", bus.fifo_wr_data); end
    checks++; if (grant_id !== '0) begin errors++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
    checks++; if (credits !== CRED_W'(DEPTH)) begin errors++; $display("FAIL reset_credits got %0d want %0d", credits, DEPTH); end
    checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL reset_credit_err got %b want 0", credit_err); end
  endtask

  task automatic test_round_robin();
    int order[$]; int fcyc[$]; int pulses;
    apply_reset();
    pulses = 0;
    bus.req_valid = '1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (fire_now) begin order.push_back(fire_idx); fcyc.push_back(c); end
      if (bus.fifo_wr_en) pulses++;
      checks++; if (bus.fifo_wr_en !== exp_wr_en || (exp_wr_en && bus.fifo_wr_data !== exp_wr_data)) begin
        errors++; $display("FAIL rr_write cyc%0d got en=%b d=%h want en=%b d=%h", c, bus.fifo_wr_en, bus.fifo_wr_data, exp_wr_en, exp_wr_data);
      end
    end
    checks++; if (pulses != 16) begin errors++; $display("FAIL rr_pulses got %0d want 16", pulses); end
    checks++; if (order.size() != 16) begin errors++; $display("FAIL rr_fires got %0d want 16", order.size()); end
    else begin
      for (int k = 0; k < 16; k++) begin
        checks++; if (order[k] != k/4 || fcyc[k] != 1 + k + k/4) begin
          errors++; $display("FAIL rr_beat%0d got owner %0d cyc %0d want owner %0d cyc %0d", k, order[k], fcyc[k], k/4, 1 + k + k/4);
        end
      end
    end
    checks++; if (credits !== '0) begin errors++; $display("FAIL rr_credits got %0d want 0", credits); end
    checks++; if (bus.req_ready !== '0) begin errors++; $display("FAIL rr_ready got %b want 0", bus.req_ready); end
  endtask

  task automatic test_single_producer();
    int runs[$]; int run; int acc; int wr_cnt;
    apply_reset();
    run = 0; acc = 0; wr_cnt = 0;
    bus.req_valid = 4'b0100;
    for (int c = 0; c < 60; c++) begin
      bus.fifo_rd_fire = (cred_m < DEPTH) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (bus.fifo_wr_en) begin
        checks++; if (bus.fifo_wr_data !== word_of(2, wr_cnt)) begin
          errors++; $display("FAIL single_data beat%0d got %h want %h", wr_cnt, bus.fifo_wr_data, word_of(2, wr_cnt));
        end
        wr_cnt++;
      end
      if (fire_now) begin
        run++; acc++;
        checks++; if (grant_id !== ID_W'(2)) begin errors++; $display("FAIL single_grant got %0d want 2", grant_id); end
        if (acc == 10) bus.req_valid = '0;
      end else if (run > 0) begin
        runs.push_back(run); run = 0;
      end
    end
    bus.fifo_rd_fire = 1'b0;
    if (run > 0) runs.push_back(run);
    checks++; if (runs.size() != 3 || runs[0] != 4 || runs[1] != 4 || runs[2] != 2) begin
      errors++; $display("FAIL single_bursts got %0d runs (%p) want 4,4,2", runs.size(), runs);
    end
    checks++; if (wr_cnt != 10) begin errors++; $display("FAIL single_writes got %0d want 10", wr_cnt); end
    checks++; if (credits !== CRED_W'(cred_m)) begin errors++; $display("FAIL single_credits got %0d want %0d", credits, cred_m); end
  endtask

  task automatic test_credit_stall();
    int acc; int guard; int fires; int pulses; int first;
    apply_reset();
    acc = 0; guard = 0;
    bus.req_valid = 4'b0010;
    while (acc < 2 && guard < 20) begin tick(); if (fire_now) acc++; guard++; end
    bus.req_valid = '0;
    repeat (2) tick();
    bus.req_valid = 4'b0010;
    guard = 0;
    while (cred_m > 0 && guard < 80) begin tick(); guard++; end
    checks++; if (guard >= 80) begin errors++; $display("FAIL stall_fill timeout credits %0d want 0", credits); end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (bus.req_ready !== '0 || bus.fifo_wr_en !== 1'b0 || grant_id !== ID_W'(1)) begin
        errors++; $display("FAIL stall_hold cyc%0d got ready=%b en=%b gid=%0d want 0 0 1", c, bus.req_ready, bus.fifo_wr_en, grant_id);
      end
    end
    bus.fifo_rd_fire = 1'b1;
    tick();
    bus.fifo_rd_fire = 1'b0;
    checks++; if (credits !== CRED_W'(1)) begin errors++; $display("FAIL stall_return got %0d want 1", credits); end
    fires = 0; pulses = 0; first = -1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (fire_now) begin fires++; if (first < 0) first = c; end
      if (bus.fifo_wr_en) pulses++;
    end
    checks++; if (fires != 1 || first != 0) begin errors++; $display("FAIL stall_fires got %0d (first %0d) want 1 (first 0)", fires, first); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL stall_pulses got %0d want 1", pulses); end
    checks++; if (credits !== '0) begin errors++; $display("FAIL stall_credits got %0d want 0", credits); end
    bus.req_valid = '0;
  endtask

  task automatic test_simultaneous();
    int guard; int fires;
    apply_reset();
    bus.req_valid = 4'b1000;
    guard = 0;
    while (cred_m > 10 && guard < 40) begin tick(); guard++; end
    checks++; if (credits !== CRED_W'(10)) begin errors++; $display("FAIL simul_start got %0d want 10", credits); end
    follow_rd = 1; fires = 0; guard = 0;
    while (fires < 8 && guard < 40) begin
      tick(); guard++;
      if (fire_now) fires++;
      checks++; if (credits !== CRED_W'(10)) begin errors++; $display("FAIL simul_credits cyc%0d got %0d want 10", guard, credits); end
    end
    checks++; if (fires != 8) begin errors++; $display("FAIL simul_fires got %0d want 8", fires); end
    follow_rd = 0; bus.fifo_rd_fire = 1'b0; bus.req_valid = '0;
  endtask

  task automatic test_credit_overflow();
    apply_reset();
    bus.fifo_rd_fire = 1'b1;
    tick();
    bus.fifo_rd_fire = 1'b0;
    checks++; if (credits !== CRED_W'(DEPTH) || credit_err !== 1'b1) begin
      errors++; $display("FAIL overflow got credits=%0d err=%b want %0d 1", credits, credit_err, DEPTH);
    end
    bus.req_valid = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL overflow_sticky cyc%0d got %b want 1", c, credit_err); end
    end
    apply_reset(); #1;
    checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL overflow_clear got %b want 0", credit_err); end
  endtask

  task automatic test_reset_mid_burst();
    int guard;
    apply_reset();
    bus.req_valid = 4'b0010;
    guard = 0;
    while (!fire_now && guard < 10) begin tick(); guard++; end
    checks++; if (bus.req_ready !== 4'b0010 || bus.fifo_wr_en !== 1'b1) begin
      errors++; $display("FAIL midrst_pre got ready=%b en=%b want 0010 1", bus.req_ready, bus.fifo_wr_en);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.req_ready !== '0 || bus.fifo_wr_en !== 1'b0 || credits !== CRED_W'(DEPTH) || grant_id !== '0) begin
      errors++; $display("FAIL midrst_async got ready=%b en=%b cred=%0d gid=%0d want 0 0 16 0", bus.req_ready, bus.fifo_wr_en, credits, grant_id);
    end
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    bus.req_valid = '1;
    guard = 0;
    fire_now = 0;
    while (!fire_now && guard < 10) begin tick(); guard++; end
    checks++; if (fire_idx != 0 || grant_id !== '0) begin errors++; $display("FAIL midrst_restart got owner %0d gid %0d want 0", fire_idx, grant_id); end
    bus.req_valid = '0;
  endtask

  task automatic test_random();
    int run;
    apply_reset();
    run = 0;
    for (int c = 0; c < 600; c++) begin
      bus.req_valid    = N'($urandom);
      bus.fifo_rd_fire = ($urandom_range(0, 99) < 40);
      tick();
      run = fire_now ? run + 1 : 0;
      checks++; if (bus.fifo_wr_en !== exp_wr_en || (exp_wr_en && bus.fifo_wr_data !== exp_wr_data)) begin
        errors++; $display("FAIL rand_write cyc%0d got en=%b d=%h want en=%b d=%h", c, bus.fifo_wr_en, bus.fifo_wr_data, exp_wr_en, exp_wr_data);
      end
      checks++; if (credits !== CRED_W'(cred_m) || credit_err !== err_m) begin
        errors++; $display("FAIL rand_credits cyc%0d got %0d/%b want %0d/%b", c, credits, credit_err, cred_m, err_m);
      end
      checks++; if (!$onehot0(bus.req_ready) || (bus.req_ready != '0 && cred_m == 0)) begin
        errors++; $display("FAIL rand_ready cyc%0d got %b with credits %0d want onehot0 and gated", c, bus.req_ready, cred_m);
      end
      checks++; if (run > MB) begin errors++; $display("FAIL rand_burst cyc%0d got run %0d want <= %0d", c, run, MB); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single_producer();
    test_credit_stall();
    test_simultaneous();
    test_credit_overflow();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
